// File: rtl/execute_stage.sv
// Execute stage of a 5-stage MIPS-style pipeline.
// The stage selects forwarded operands and runs the ALU. An iterative
// restoring divider stalls the front of the pipeline while it works. The
// stage also computes the branch target and owns the EX/MEM register.
//
// Divider FSM
//   state  | meaning
//   S_IDLE | no divide in flight; a divide op presented here issues
//   S_DIV  | one restoring iteration per cycle, count runs N_BITS -> 0
//   S_DONE | quotient/remainder valid; EX/MEM captures on this cycle's edge
module execute_stage #(
  parameter int N_BITS     = 32,
  parameter int N_BITS_REG = 5
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic                  i_flush,
  input  logic                  i_regDst,
  input  logic                  i_aluSrc,
  input  logic [3:0]            i_aluOp,
  input  logic                  i_branch,
  input  logic                  i_memRead,
  input  logic                  i_memWrite,
  input  logic                  i_memToReg,
  input  logic                  i_regWrite,
  input  logic [N_BITS-1:0]     i_pcPlus4,
  input  logic [N_BITS-1:0]     i_datoLeido1,
  input  logic [N_BITS-1:0]     i_datoLeido2,
  input  logic [N_BITS-1:0]     i_immediate,
  input  logic [4:0]            i_shamt,
  input  logic [N_BITS_REG-1:0] i_rt,
  input  logic [N_BITS_REG-1:0] i_rd,
  input  logic [1:0]            i_forwardA,
  input  logic [1:0]            i_forwardB,
  input  logic [N_BITS-1:0]     i_aluResult_MEM,
  input  logic [N_BITS-1:0]     i_writeData_WB,
  output logic                  o_stall,
  output logic                  o_branch,
  output logic                  o_memRead,
  output logic                  o_memWrite,
  output logic                  o_memToReg,
  output logic                  o_regWrite,
  output logic                  o_ceroSignal,
  output logic [N_BITS-1:0]     o_aluResult,
  output logic [N_BITS-1:0]     o_datoLeido2,
  output logic [N_BITS_REG-1:0] o_rt_OR_rd,
  output logic [N_BITS-1:0]     o_branchTarget
);

  localparam int CNT_W = $clog2(N_BITS + 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_LUI  = 4'd11;
  localparam logic [3:0] OP_DIVU = 4'd12;
  localparam logic [3:0] OP_REMU = 4'd13;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  div_state_t        state;
  logic [CNT_W-1:0]  div_count;
  logic [N_BITS-1:0] div_quo;
  logic [N_BITS-1:0] div_rem;
  logic [N_BITS-1:0] div_dvsr;
  logic [N_BITS:0]   rem_shift;
  logic [N_BITS:0]   rem_diff;

  logic [N_BITS-1:0] fwd_a;
  logic [N_BITS-1:0] fwd_b;
  logic [N_BITS-1:0] op_a;
  logic [N_BITS-1:0] op_b;
  logic [N_BITS-1:0] alu_result;
  logic [N_BITS-1:0] branch_target;
  logic [N_BITS_REG-1:0] dest;
  logic              is_div;
  logic              div_issue;

  // Forwarding muxes for both source operands; code 11 falls back to the register file.
  always_comb begin
    fwd_a = i_datoLeido1;
    fwd_b = i_datoLeido2;
    case (i_forwardA)
      2'b01:   fwd_a = i_writeData_WB;
      2'b10:   fwd_a = i_aluResult_MEM;
      default: fwd_a = i_datoLeido1;
    endcase
    case (i_forwardB)
      2'b01:   fwd_b = i_writeData_WB;
      2'b10:   fwd_b = i_aluResult_MEM;
      default: fwd_b = i_datoLeido2;
    endcase
  end

  assign op_a = fwd_a;
  assign op_b = i_aluSrc ? i_immediate : fwd_b;

  assign is_div    = (i_aluOp == OP_DIVU) || (i_aluOp == OP_REMU);
  assign div_issue = (state == S_IDLE) && is_div && i_valid && !i_flush;

  // Reset gates the stall so that it reads 0 while reset is held, even if a
  // divide is still sitting on the inputs.
  assign o_stall = i_reset && (div_issue || (state == S_DIV));

  // One restoring step: shift the next dividend bit in, try to subtract.
  assign rem_shift = {div_rem, div_quo[N_BITS-1]};
  assign rem_diff  = rem_shift - {1'b0, div_dvsr};

  // ALU operation select; divide results come from the divider registers.
  always_comb begin
    alu_result = '0;
    case (i_aluOp)
      OP_ADD:  alu_result = op_a + op_b;
      OP_SUB:  alu_result = op_a - op_b;
      OP_AND:  alu_result = op_a & op_b;
      OP_OR:   alu_result = op_a | op_b;
      OP_XOR:  alu_result = op_a ^ op_b;
      OP_NOR:  alu_result = ~(op_a | op_b);
      OP_SLT:  alu_result = {{(N_BITS-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu_result = {{(N_BITS-1){1'b0}}, (op_a < op_b)};
      OP_SLL:  alu_result = op_b << i_shamt;
      OP_SRL:  alu_result = op_b >> i_shamt;
      OP_SRA:  alu_result = $unsigned($signed(op_b) >>> i_shamt);
      OP_LUI:  alu_result = op_b << 16;
      OP_DIVU: alu_result = div_quo;
      OP_REMU: alu_result = div_rem;
      default: alu_result = '0;
    endcase
  end

  assign branch_target = i_pcPlus4 + (i_immediate << 2);
  assign dest          = i_regDst ? i_rd : i_rt;

  // Divider FSM and its datapath registers; flush aborts any divide in flight.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= S_IDLE;
      div_count <= '0;
      div_quo   <= '0;
      div_rem   <= '0;
      div_dvsr  <= '0;
    end else if (i_flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (div_issue) begin
            state     <= S_DIV;
            div_quo   <= op_a;
            div_dvsr  <= op_b;
            div_rem   <= '0;
            div_count <= CNT_W'(N_BITS);
          end
        end
        S_DIV: begin
          // A zero divisor always "fits", which yields all-ones quotient and
          // leaves the dividend as remainder without any special casing.
          div_quo   <= {div_quo[N_BITS-2:0], ~rem_diff[N_BITS]};
          div_rem   <= rem_diff[N_BITS] ? rem_shift[N_BITS-1:0] : rem_diff[N_BITS-1:0];
          div_count <= div_count - CNT_W'(1);
          if (div_count == CNT_W'(1)) begin
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // EX/MEM pipeline register: reset, then flush/stall bubbles, then load, else hold.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_branch       <= 1'b0;
      o_memRead      <= 1'b0;
      o_memWrite     <= 1'b0;
      o_memToReg     <= 1'b0;
      o_regWrite     <= 1'b0;
      o_ceroSignal   <= 1'b0;
      o_aluResult    <= '0;
      o_datoLeido2   <= '0;
      o_rt_OR_rd     <= '0;
      o_branchTarget <= '0;
    end else if (i_flush || o_stall) begin
      o_branch       <= 1'b0;
      o_memRead      <= 1'b0;
      o_memWrite     <= 1'b0;
      o_memToReg     <= 1'b0;
      o_regWrite     <= 1'b0;
      o_ceroSignal   <= 1'b0;
      o_aluResult    <= '0;
      o_datoLeido2   <= '0;
      o_rt_OR_rd     <= '0;
      o_branchTarget <= '0;
    end else if (i_valid) begin
      o_branch       <= i_branch;
      o_memRead      <= i_memRead;
      o_memWrite     <= i_memWrite;
      o_memToReg     <= i_memToReg;
      o_regWrite     <= i_regWrite;
      o_ceroSignal   <= (alu_result == '0);
      o_aluResult    <= alu_result;
      o_datoLeido2   <= fwd_b;
      o_rt_OR_rd     <= dest;
      o_branchTarget <= branch_target;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: a table of single-cycle ALU vectors, then
// hand-written sequences for divides, flush, hold and asynchronous reset.
module tb_execute_stage;

  logic        i_clk;
  logic        i_reset;
  logic        i_valid;
  logic        i_flush;
  logic        i_regDst;
  logic        i_aluSrc;
  logic [3:0]  i_aluOp;
  logic        i_branch, i_memRead, i_memWrite, i_memToReg, i_regWrite;
  logic [31:0] i_pcPlus4, i_datoLeido1, i_datoLeido2, i_immediate;
  logic [4:0]  i_shamt;
  logic [4:0]  i_rt, i_rd;
  logic [1:0]  i_forwardA, i_forwardB;
  logic [31:0] i_aluResult_MEM, i_writeData_WB;
  logic        o_stall;
  logic        o_branch, o_memRead, o_memWrite, o_memToReg, o_regWrite;
  logic        o_ceroSignal;
  logic [31:0] o_aluResult, o_datoLeido2, o_branchTarget;
  logic [4:0]  o_rt_OR_rd;

  execute_stage #(.N_BITS(32), .N_BITS_REG(5)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_flush(i_flush),
    .i_regDst(i_regDst), .i_aluSrc(i_aluSrc), .i_aluOp(i_aluOp),
    .i_branch(i_branch), .i_memRead(i_memRead), .i_memWrite(i_memWrite),
    .i_memToReg(i_memToReg), .i_regWrite(i_regWrite),
    .i_pcPlus4(i_pcPlus4), .i_datoLeido1(i_datoLeido1), .i_datoLeido2(i_datoLeido2),
    .i_immediate(i_immediate), .i_shamt(i_shamt), .i_rt(i_rt), .i_rd(i_rd),
    .i_forwardA(i_forwardA), .i_forwardB(i_forwardB),
    .i_aluResult_MEM(i_aluResult_MEM), .i_writeData_WB(i_writeData_WB),
    .o_stall(o_stall), .o_branch(o_branch), .o_memRead(o_memRead),
    .o_memWrite(o_memWrite), .o_memToReg(o_memToReg), .o_regWrite(o_regWrite),
    .o_ceroSignal(o_ceroSignal), .o_aluResult(o_aluResult),
    .o_datoLeido2(o_datoLeido2), .o_rt_OR_rd(o_rt_OR_rd),
    .o_branchTarget(o_branchTarget)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        src;
    logic        dst;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [31:0] mem;
    logic [31:0] wb;
    logic [31:0] pc;
    logic [4:0]  ctrl;   // {branch, memRead, memWrite, memToReg, regWrite}
    logic [31:0] e_res;
    logic        e_zero;
    logic [31:0] e_st;
    logic [4:0]  e_dst;
    logic [31:0] e_tgt;
  } vec_t;

  vec_t vecs[15];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ctrl_out();
    return {27'd0, o_branch, o_memRead, o_memWrite, o_memToReg, o_regWrite};
  endfunction

  task automatic apply(input vec_t v, input logic valid);
    i_aluOp         = v.op;
    i_forwardA      = v.fa;
    i_forwardB      = v.fb;
    i_aluSrc        = v.src;
    i_regDst        = v.dst;
    i_datoLeido1    = v.a;
    i_datoLeido2    = v.b;
    i_immediate     = v.imm;
    i_shamt         = v.shamt;
    i_aluResult_MEM = v.mem;
    i_writeData_WB  = v.wb;
    i_pcPlus4       = v.pc;
    {i_branch, i_memRead, i_memWrite, i_memToReg, i_regWrite} = v.ctrl;
    i_valid         = valid;
  endtask

  task automatic check_vec(input vec_t v, input string tag);
    chk({tag, "_result"}, o_aluResult, v.e_res);
    chk({tag, "_zero"},   {31'd0, o_ceroSignal}, {31'd0, v.e_zero});
    chk({tag, "_store"},  o_datoLeido2, v.e_st);
    chk({tag, "_dest"},   {27'd0, o_rt_OR_rd}, {27'd0, v.e_dst});
    chk({tag, "_target"}, o_branchTarget, v.e_tgt);
    chk({tag, "_ctrl"},   ctrl_out(), {27'd0, v.ctrl});
  endtask

  // Issue a divide, count stall cycles, check bubbles, then the captured result.
  task automatic run_div(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string tag);
    int  cnt;
    logic bubble_bad;
    i_aluOp = op; i_forwardA = 2'b00; i_forwardB = 2'b00; i_aluSrc = 1'b0; i_regDst = 1'b1;
    i_datoLeido1 = a; i_datoLeido2 = b; i_immediate = 32'd0; i_pcPlus4 = 32'd0;
    {i_branch, i_memRead, i_memWrite, i_memToReg, i_regWrite} = 5'b00001;
    i_valid = 1'b1; i_flush = 1'b0;
    #1;
    chk({tag, "_stall_issue"}, {31'd0, o_stall}, 32'd1);
    cnt = 0;
    bubble_bad = 1'b0;
    while (o_stall && cnt < 100) begin
      @(posedge i_clk); #1;
      cnt++;
      if (ctrl_out() != 32'd0 || o_aluResult != 32'd0 || o_datoLeido2 != 32'd0)
        bubble_bad = 1'b1;
    end
    chk({tag, "_stall_cycles"}, cnt, 32'd33);
    chk({tag, "_bubble"}, {31'd0, bubble_bad}, 32'd0);
    @(posedge i_clk); #1;
    chk({tag, "_result"}, o_aluResult, exp);
    chk({tag, "_ctrl"}, ctrl_out(), 32'd1);
    chk({tag, "_dest"}, {27'd0, o_rt_OR_rd}, 32'd9);
    chk({tag, "_zero"}, {31'd0, o_ceroSignal}, {31'd0, (exp == 32'd0)});
    i_valid = 1'b0;
    i_aluOp = 4'd0;
  endtask

  initial begin
    //          op     fa     fb     src   dst   a             b             imm           sh     mem    wb          pc           ctrl      res           z     st            dst    tgt
    vecs[0]  = '{4'd0,  2'd2, 2'd0, 1'b0, 1'b1, 32'h11,       32'd7,        32'd0,        5'd0,  32'd5, 32'd0,      32'd0,       5'b00001, 32'd12,       1'b0, 32'd7,        5'd9, 32'd0};
    vecs[1]  = '{4'd1,  2'd0, 2'd0, 1'b0, 1'b0, 32'd9,        32'd9,        32'h4,        5'd0,  32'd0, 32'd0,      32'h100,     5'b10000, 32'd0,        1'b1, 32'd9,        5'd3, 32'h110};
    vecs[2]  = '{4'd10, 2'd0, 2'd0, 1'b0, 1'b1, 32'd0,        32'h80000000, 32'd0,        5'd4,  32'd0, 32'd0,      32'd0,       5'b00001, 32'hF8000000, 1'b0, 32'h80000000, 5'd9, 32'd0};
    vecs[3]  = '{4'd6,  2'd0, 2'd0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd1,        32'd0,        5'd0,  32'd0, 32'd0,      32'd0,       5'b00001, 32'd1,        1'b0, 32'd1,        5'd9, 32'd0};
    vecs[4]  = '{4'd7,  2'd0, 2'd0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd1,        32'd0,        5'd0,  32'd0, 32'd0,      32'd0,       5'b00001, 32'd0,        1'b1, 32'd1,        5'd9, 32'd0};
    vecs[5]  = '{4'd2,  2'd3, 2'd1, 1'b0, 1'b1, 32'hFF00,     32'hDEAD,     32'd0,        5'd0,  32'd0, 32'hF0F0,   32'd0,       5'b00001, 32'hF000,     1'b0, 32'hF0F0,     5'd9, 32'd0};
    vecs[6]  = '{4'd3,  2'd0, 2'd0, 1'b1, 1'b0, 32'h1200,     32'h55,       32'h34,       5'd0,  32'd0, 32'd0,      32'd0,       5'b01011, 32'h1234,     1'b0, 32'h55,       5'd3, 32'hD0};
    vecs[7]  = '{4'd4,  2'd0, 2'd0, 1'b0, 1'b1, 32'hFFFF0000, 32'h0F0F0F0F, 32'd0,        5'd0,  32'd0, 32'd0,      32'd0,       5'b00100, 32'hF0F00F0F, 1'b0, 32'h0F0F0F0F, 5'd9, 32'd0};
    vecs[8]  = '{4'd5,  2'd0, 2'd0, 1'b0, 1'b1, 32'd0,        32'd0,        32'd0,        5'd0,  32'd0, 32'd0,      32'd0,       5'b00001, 32'hFFFFFFFF, 1'b0, 32'd0,        5'd9, 32'd0};
    vecs[9]  = '{4'd8,  2'd0, 2'd0, 1'b0, 1'b1, 32'd0,        32'd1,        32'd0,        5'd31, 32'd0, 32'd0,      32'd0,       5'b00001, 32'h80000000, 1'b0, 32'd1,        5'd9, 32'd0};
    vecs[10] = '{4'd9,  2'd0, 2'd0, 1'b0, 1'b1, 32'd0,        32'h80000000, 32'd0,        5'd31, 32'd0, 32'd0,      32'd0,       5'b00001, 32'd1,        1'b0, 32'h80000000, 5'd9, 32'd0};
    vecs[11] = '{4'd11, 2'd0, 2'd0, 1'b1, 1'b0, 32'd0,        32'd0,        32'h1234,     5'd0,  32'd0, 32'd0,      32'h1000,    5'b00001, 32'h12340000, 1'b0, 32'd0,        5'd3, 32'h58D0};
    vecs[12] = '{4'd0,  2'd0, 2'd2, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd99,       32'd0,        5'd0,  32'd1, 32'd0,      32'd0,       5'b00001, 32'd0,        1'b1, 32'd1,        5'd9, 32'd0};
    vecs[13] = '{4'd1,  2'd0, 2'd0, 1'b0, 1'b0, 32'd0,        32'd1,        32'hFFFFFFFF, 5'd0,  32'd0, 32'd0,      32'h100,     5'b10000, 32'hFFFFFFFF, 1'b0, 32'd1,        5'd3, 32'hFC};
    vecs[14] = '{4'd15, 2'd0, 2'd0, 1'b0, 1'b1, 32'd5,        32'd6,        32'd0,        5'd0,  32'd0, 32'd0,      32'd0,       5'b01110, 32'd0,        1'b1, 32'd6,        5'd9, 32'd0};

    // Reset state
    i_reset = 1'b0;
    i_flush = 1'b0;
    i_rt = 5'd3;
    i_rd = 5'd9;
    apply(vecs[0], 1'b0);
    #2;
    chk("reset_stall",  {31'd0, o_stall}, 32'd0);
    chk("reset_result", o_aluResult, 32'd0);
    chk("reset_ctrl",   ctrl_out(), 32'd0);
    chk("reset_target", o_branchTarget, 32'd0);
    chk("reset_dest",   {27'd0, o_rt_OR_rd}, 32'd0);
    chk("reset_zero",   {31'd0, o_ceroSignal}, 32'd0);
    #10;
    i_reset = 1'b1;
    @(posedge i_clk); #1;

    // Single-cycle ALU vectors
    for (int i = 0; i < 15; i++) begin
      apply(vecs[i], 1'b1);
      @(posedge i_clk); #1;
      chk($sformatf("vec%0d_stall", i), {31'd0, o_stall}, 32'd0);
      check_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Hold: i_valid low keeps the previous contents
    apply(vecs[0], 1'b0);
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    check_vec(vecs[14], "hold");

    // Divides
    run_div(4'd12, 32'd100,   32'd7, 32'd14,         "divu_100_7");
    run_div(4'd13, 32'd100,   32'd7, 32'd2,          "remu_100_7");
    run_div(4'd12, 32'h1234,  32'd0, 32'hFFFFFFFF,   "divu_by0");
    run_div(4'd13, 32'h1234,  32'd0, 32'h1234,       "remu_by0");

    // Flush mid-divide
    i_aluOp = 4'd12; i_datoLeido1 = 32'd100; i_datoLeido2 = 32'd7; i_valid = 1'b1;
    @(posedge i_clk); #1;
    for (int c = 0; c < 9; c++) begin
      @(posedge i_clk); #1;
    end
    chk("flush_pre_stall", {31'd0, o_stall}, 32'd1);
    i_flush = 1'b1;
    @(posedge i_clk); #1;
    chk("flush_stall_drop", {31'd0, o_stall}, 32'd0);
    chk("flush_result", o_aluResult, 32'd0);
    chk("flush_ctrl", ctrl_out(), 32'd0);
    i_flush = 1'b0;
    i_aluOp = 4'd0; i_datoLeido1 = 32'd2; i_datoLeido2 = 32'd3;
    @(posedge i_clk); #1;
    chk("post_flush_stall", {31'd0, o_stall}, 32'd0);
    chk("post_flush_add", o_aluResult, 32'd5);
    chk("post_flush_ctrl", ctrl_out(), 32'd1);

    // Async reset clears non-zero outputs without a clock edge
    #2;
    i_reset = 1'b0;
    #1;
    chk("areset_result", o_aluResult, 32'd0);
    chk("areset_ctrl", ctrl_out(), 32'd0);
    chk("areset_dest", {27'd0, o_rt_OR_rd}, 32'd0);
    #1;
    i_reset = 1'b1;
    i_valid = 1'b0;
    @(posedge i_clk); #1;

    // Async reset mid-divide
    i_aluOp = 4'd12; i_datoLeido1 = 32'd100; i_datoLeido2 = 32'd7; i_valid = 1'b1;
    @(posedge i_clk); #1;
    for (int c = 0; c < 4; c++) begin
      @(posedge i_clk); #1;
    end
    chk("rst_div_pre_stall", {31'd0, o_stall}, 32'd1);
    #2;
    i_reset = 1'b0;
    #1;
    chk("rst_div_stall", {31'd0, o_stall}, 32'd0);
    chk("rst_div_ctrl", ctrl_out(), 32'd0);
    i_valid = 1'b0;
    i_aluOp = 4'd0;
    #1;
    i_reset = 1'b1;
    @(posedge i_clk); #1;

    // A full divide after the aborted one still takes the normal latency
    run_div(4'd12, 32'd100, 32'd7, 32'd14, "divu_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the 5-stage MIPS-style pipeline. Sits between the ID/EX register and the memory stage.
- Selects forwarded operands and runs the ALU. An iterative unsigned divider stalls the pipeline while it runs.
- Computes the branch target and zero flag.
- Owns the EX/MEM pipeline register whose outputs feed the memory stage directly.

Parameters:
- N_BITS, 32, datapath width.
- N_BITS_REG, 5, register-address width. Instantiate with the same value as the memory stage.

Ports:
- i_clk  in  1  single clock, posedge only
- i_reset  in  1  asynchronous, active-low reset
- i_valid  in  1  stage enable; low = hold EX/MEM register
- i_flush  in  1  load bubble into EX/MEM, abort divide
- i_regDst  in  1  1: destination = rd, 0: rt
- i_aluSrc  in  1  1: operand B = immediate
- i_aluOp  in  4  decoded ALU operation
- i_branch, i_memRead, i_memWrite, i_memToReg, i_regWrite  in  1 each  control pass-through
- i_pcPlus4  in  N_BITS  PC+4 of this instruction
- i_datoLeido1, i_datoLeido2  in  N_BITS  register-file reads (rs, rt)
- i_immediate  in  N_BITS  sign-extended immediate
- i_shamt  in  5  shift amount
- i_rt, i_rd  in  N_BITS_REG  register addresses
- i_forwardA, i_forwardB  in  2  00 register file, 01 WB data, 10 MEM ALU result, 11 register file
- i_aluResult_MEM  in  N_BITS  forward from EX/MEM
- i_writeData_WB  in  N_BITS  forward from MEM/WB
- o_stall  out  1  combinational; freeze PC, IF/ID, ID/EX
- o_branch, o_memRead, o_memWrite, o_memToReg, o_regWrite  out  1 each  registered
- o_ceroSignal  out  1  registered: ALU result == 0
- o_aluResult  out  N_BITS  registered
- o_datoLeido2  out  N_BITS  registered forwarded operand B, before the immediate mux (store data)
- o_rt_OR_rd  out  N_BITS_REG  registered destination
- o_branchTarget  out  N_BITS  registered: i_pcPlus4 + (i_immediate << 2), truncated to N_BITS

Behaviour:
- Operand paths:
  - fwdA = mux(i_forwardA); fwdB = mux(i_forwardB).
  - opA = fwdA; opB = i_aluSrc ? i_immediate : fwdB.
- i_aluOp encoding:
  - 0 ADD, 1 SUB (wrap-around, no overflow trap)
  - 2 AND, 3 OR, 4 XOR, 5 NOR
  - 6 SLT signed, 7 SLTU (result 1 or 0)
  - 8 SLL, 9 SRL, 10 SRA: opB shifted by i_shamt
  - 11 LUI: opB << 16
  - 12 DIVU quotient, 13 REMU remainder
  - 14–15 result 0
- Divider FSM (restoring, 1 bit/cycle):
  - IDLE → DIV when i_valid & !i_flush & aluOp ∈ {12,13}: latch opA/opB, count = N_BITS.
  - DIV: one iteration per cycle; when count reaches 0 → DONE.
  - DONE → IDLE unconditionally after one cycle.
- o_stall = (state==IDLE & divide op & i_valid & !i_flush) | state==DIV.
  - Upstream holds all inputs stable while o_stall = 1.
- Divide latency: result is captured into EX/MEM on the DONE-cycle edge, N_BITS+1 edges after issue.
- Divide by zero: quotient all ones, remainder = dividend, same latency as any other divide.
- EX/MEM register update priority at each posedge:
  - 1. reset: all outputs 0.
  - 2. i_flush: bubble (all control outputs 0, data 0); FSM → IDLE.
  - 3. o_stall: bubble.
  - 4. i_valid: load computed values.
  - 5. else hold.
- i_flush while in DIV aborts the divide. No result is written; o_stall drops the next cycle.
- Asynchronous reset mid-divide: FSM → IDLE, all outputs and internal state 0 immediately.
- Reset values: every output 0, including o_stall (FSM IDLE).
- Non-divide ops: single cycle; the EX/MEM register reflects inputs one posedge after presentation.

Test Plan:
- ADD, forwardA=10, i_aluResult_MEM=5, i_datoLeido2=7, aluSrc=0 → o_aluResult=12, o_ceroSignal=0 next edge.
- SUB 9−9 with branch=1, pcPlus4=0x100, imm=0x4 → o_aluResult=0, o_ceroSignal=1, o_branchTarget=0x110, o_branch=1.
- DIVU 100/7 → o_stall high 33 cycles (N_BITS+1). EX/MEM shows bubbles (all control 0) during the stall, then o_aluResult=14; REMU gives 2.
- DIVU x/0 with x=0x1234 → quotient 0xFFFFFFFF; REMU → 0x1234.
- i_flush asserted mid-divide (cycle 10) → o_stall low the next cycle, EX/MEM all zero. Reset asserted mid-divide → all outputs 0 asynchronously.
- SRA 0x80000000 by 4 → 0xF8000000. SLT −1 < 1 → 1, SLTU → 0. i_valid=0 → outputs hold previous values.
